// File: rtl/qrd_skew_feeder.sv
// qrd_skew_feeder: double-buffered input formatter for the QRD systolic core.
// Collects [H | y] one column per beat into two banks, then replays each
// matrix as N row streams skewed by one cycle per row.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   column beat handshake
//   in_col_r / in_col_i   one column, row k at bits [k*W +: W]
//   array_ready           downstream may start a new frame (sampled at start)
//   row_r / row_i         skewed row outputs, row k at bits [k*W +: W]
//   row_v / row_f         per-row element valid / first-element flag
//   frame_active          high for the 2N cycles of an emitted frame

module qrd_skew_feeder #(
    parameter int N = 4,
    parameter int W = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_col_r,
    input  logic [N*W-1:0] in_col_i,
    input  logic           array_ready,
    output logic [N*W-1:0] row_r,
    output logic [N*W-1:0] row_i,
    output logic [N-1:0]   row_v,
    output logic [N-1:0]   row_f,
    output logic           frame_active
);

    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(2 * N);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_d;

    logic [N*W-1:0] mem_r [2][N+1];
    logic [N*W-1:0] mem_i [2][N+1];

    logic [1:0]    full;
    logic          wb;
    logic          rb;
    logic [CW-1:0] wcol;

    logic acc;
    logic wr_last;
    logic last;
    logic rel;

    // Ready depends only on registered flags, never on in_valid/array_ready.
    assign in_ready = !full[wb];
    assign acc      = in_valid && in_ready;
    assign wr_last  = acc && (wcol == CW'(N));
    assign last     = (s_q == SW'(2 * N - 1));

    // Next-state logic: a frame never stalls once started; array_ready is
    // only consulted at the start of a frame (including a chained start).
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        rel     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full[rb] && array_ready) begin
                    state_d = EMIT;
                    s_d     = '0;
                end
            end
            EMIT: begin
                if (!last) begin
                    s_d = s_q + 1'b1;
                end else begin
                    rel = 1'b1;
                    s_d = '0;
                    if (full[!rb] && array_ready) begin
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
        end
    end

    // Bank bookkeeping. A completing write and a release always touch
    // different banks: the write bank is empty, the read bank is full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            wcol <= '0;
        end else begin
            if (acc) begin
                wcol <= wr_last ? '0 : wcol + 1'b1;
            end
            if (wr_last) begin
                full[wb] <= 1'b1;
                wb       <= !wb;
            end
            if (rel) begin
                full[rb] <= 1'b0;
                rb       <= !rb;
            end
        end
    end

    // Bank storage needs no reset: the full flags gate all reads.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_r[wb][wcol] <= in_col_r;
            mem_i[wb][wcol] <= in_col_i;
        end
    end

    assign frame_active = (state_q == EMIT);

    // Slot s: row k shows column j = s - k when that column exists.
    always_comb begin
        row_r = '0;
        row_i = '0;
        row_v = '0;
        row_f = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j <= N; j++) begin
                if (state_q == EMIT && int'(s_q) == j + k) begin
                    row_r[k*W +: W] = mem_r[rb][CW'(j)][k*W +: W];
                    row_i[k*W +: W] = mem_i[rb][CW'(j)][k*W +: W];
                    row_v[k]        = 1'b1;
                    row_f[k]        = (j == 0);
                end
            end
        end
    end

endmodule
